// File: rtl/out_port_uart_tx.sv
// Output-port UART transmitter: buffers bytes written by the datapath in a small FIFO and
// sends each one as an 8N1 frame, back-to-back when the FIFO still holds data.
module out_port_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Out_Portin,
  input  logic [31:0] Busout,
  input  logic        ovf_clr,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0]  DepthC    = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLastC = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q;
  logic [BaudW-1:0]  baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q, busy_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, empty_q, ovf_q;

  logic              baud_last, pop, wr_ok, drop;
  logic [7:0]        pop_byte;
  logic              unused_busout;

  assign unused_busout = ^Busout[31:8];
  assign baud_last     = (baud_q == BaudLastC);

  always_comb begin
    pop = 1'b0;
    if (state_q == StIdle && count_q != '0) pop = 1'b1;
    // End of stop bit may chain straight into the next frame, even from a same-edge write.
    if (state_q == StStop && baud_last && (count_q != '0 || Out_Portin)) pop = 1'b1;
    wr_ok    = Out_Portin && ((count_q < DepthC) || pop);
    drop     = Out_Portin && !wr_ok;
    // An empty FIFO popping on the same edge as a write passes the bus byte straight through.
    pop_byte = (count_q == '0) ? Busout[7:0] : mem_q[rd_ptr_q];
    count_d  = count_q;
    unique case ({wr_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= Busout[7:0];
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == DepthC);
      empty_q <= (count_d == '0);
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q <= pop_byte;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= pop_byte;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: directed scenarios plus random traffic, every cycle checked
// against a frame-timer/queue model of the transmitter.
module tb_out_port_uart_tx;
  localparam int unsigned Cpb      = 4;
  localparam int unsigned Depth    = 4;
  localparam int unsigned FrameLen = 10 * Cpb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr  = 1'b0;
  logic [31:0] bus = '0;
  logic        clr = 1'b0;
  logic        tx, busy, full, empty, ovf;

  int vectors     = 0;
  int miscompares = 0;

  // Model: a frame is a timer 0..FrameLen-1 over bits {start, d0..d7, stop}.
  bit         m_active;
  int         m_t;
  logic [7:0] m_byte;
  logic [7:0] m_q[$];
  bit         m_ovf;

  out_port_uart_tx #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(Depth)) dut (
    .clk       (clk),
    .Reset     (rst),
    .Out_Portin(wr),
    .Busout    (bus),
    .ovf_clr   (clr),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (full),
    .fifo_empty(empty),
    .overflow  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int pos;
    if (!m_active) return 1'b1;
    pos = m_t / Cpb;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_byte[pos-1];
  endfunction

  task automatic check_all();
    check1("tx", tx, exp_tx());
    check1("busy", busy, m_active);
    check1("fifo_full", full, m_q.size() == Depth);
    check1("fifo_empty", empty, m_q.size() == 0);
    check1("overflow", ovf, m_ovf);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_byte   = '0;
    m_q.delete();
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [31:0] d, input logic c);
    bit         pop, acc;
    logic [7:0] nb;
    pop = 1'b0;
    nb  = '0;
    if (!m_active && m_q.size() > 0) pop = 1'b1;
    if (m_active && m_t == FrameLen - 1 && (m_q.size() > 0 || w)) pop = 1'b1;
    acc = w && (m_q.size() < Depth || pop);
    if (acc) m_q.push_back(d[7:0]);
    if (pop) nb = m_q.pop_front();
    if (w && !acc) m_ovf = 1'b1;
    else if (c)    m_ovf = 1'b0;
    if (m_active) begin
      if (m_t == FrameLen - 1) begin
        if (pop) begin
          m_t    = 0;
          m_byte = nb;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_t++;
      end
    end else if (pop) begin
      m_active = 1'b1;
      m_t      = 0;
      m_byte   = nb;
    end
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic c);
    wr  = w;
    bus = d;
    clr = c;
    model_edge(w, d, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // Single frame of 0xA5.
    step(1'b1, 32'h0000_00A5, 1'b0);
    idle(45);

    // Three back-to-back frames.
    step(1'b1, 32'h0000_0011, 1'b0);
    step(1'b1, 32'h0000_0022, 1'b0);
    step(1'b1, 32'h0000_0033, 1'b0);
    idle(125);

    // Six writes from idle: fifth fills the FIFO, sixth is dropped.
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b1);
    idle(210);

    // Full FIFO with a write landing exactly on the stop-bit pop.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 220; i++)
      step(m_active && m_t == FrameLen - 1 && m_q.size() == Depth, $urandom, 1'b0);
    idle(10);

    // Reset mid-DATA with two bytes queued.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
    idle(10);
    async_reset();
    idle(60);

    // Upper bus bits ignored.
    step(1'b1, 32'hFFFF_FF00, 1'b0);
    idle(45);

    // Random traffic with occasional overflow clears.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 19) == 0);
    idle(250);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
Serial transmitter at the consumer end of the CPU output port. It captures bytes written by the datapath through Out_Portin/Busout and buffers them in a small FIFO. It sends each byte as an 8N1 UART frame on a single line. It sits beside the output port register in the datapath and decouples program stores from the slow serial line.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal values are 2 or more.
FIFO_DEPTH, 4, number of byte entries; must be a power of 2, 2 or more.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Out_Portin  input  1  write strobe; one byte is accepted per cycle in which it is high.
Busout  input  32  datapath bus; bits [7:0] are the byte to send; bits [31:8] are ignored.
ovf_clr  input  1  synchronous clear of the sticky overflow flag.
tx  output  1  serial line; idle level is high.
busy  output  1  high while a frame is in progress (START, DATA or STOP state).
fifo_full  output  1  count equals FIFO_DEPTH.
fifo_empty  output  1  count equals 0.
overflow  output  1  sticky flag; set when a write is dropped.

Behaviour:
- Reset (asynchronous, takes effect at any time, including mid-frame):
  - FSM goes to IDLE; FIFO count, read pointer and write pointer go to 0.
  - Outputs: tx=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0.
  - Any partial frame is abandoned; tx returns high immediately.
- FIFO:
  - Circular buffer with pointer wrap at FIFO_DEPTH.
  - Write accepted when Out_Portin=1 and (count<FIFO_DEPTH, or a pop happens in the same cycle).
  - Write when full with no pop in the same cycle: byte dropped, overflow set on that edge.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - fifo_full and fifo_empty are registered, derived from the post-edge count.
- overflow: set by a dropped write; cleared by ovf_clr. If both happen in the same cycle, set wins.
- FSM states are IDLE, START, DATA, STOP, with bit counter bit_idx 0..7 and baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. On an edge where count>0, pop the head into shift register and go to START with baud counter 0. A byte written at edge k gives its start bit from edge k+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle:
    - If count>0 (counting a write accepted that same edge), pop and go directly to START. There is no idle gap between back-to-back frames.
    - Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx is driven from a register; no combinational glitches.
- busy=1 in START, DATA and STOP.
- A pop removes the entry from the FIFO immediately, so fifo_full can deassert while the frame is still being sent.
- Writes are accepted in every state, including mid-frame.

Test Plan:
1. CLKS_PER_BIT=4. Reset, then write Busout=0x000000A5 for one cycle -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. busy high for exactly 40 cycles, fifo_empty back to 1.
2. Write 0x11, 0x22, 0x33 on consecutive cycles -> three frames back-to-back, 120 cycles total with tx never idle between stop and start. Bytes arrive in order 0x11, 0x22, 0x33.
3. FIFO_DEPTH=4. Write 6 bytes on consecutive cycles starting from idle -> first byte is popped at the second edge, so 5 bytes are accepted, the 6th is dropped. overflow=1 and fifo_full=1, then 5 frames transmitted. ovf_clr pulse -> overflow=0.
4. FIFO full, with a write on the exact cycle STOP ends and pops -> write accepted, no overflow, fifo_full stays 1.
5. Assert Reset mid-DATA while 2 bytes are queued -> tx=1, busy=0, fifo_empty=1 immediately. No further frames after Reset releases.
6. Write 0xFFFFFF00 -> only 0x00 is sent (upper bits ignored): 9 low bit-times, then a high stop bit.
